riscv_trap_ctrl: RTL and testbench
==================================

# riscv_trap_ctrl

Parametrised trap/interrupt controller for the Mini-RISC-V core. It merges the `ecall` exception with `N_IRQ` external interrupt lines (UART and other peripherals). It adds per-line synchronisation, level/edge mode, per-line and global enables, fixed priority, and cause reporting. It drives the `trapping` / `trigger_trap` / `trigger_trap_ret` signals consumed by fetch, decode and the CSR unit.

## Interface
Parameters:
- `N_IRQ`, 4: number of external interrupt lines, 1..16.
- `SYNC_STAGES`, 2: synchroniser flops per irq line, 2..3.
- `EDGE_MASK`, `'0`: bit i=1 makes line i rising-edge triggered; bit i=0 makes it level triggered.

Ports:
- `clk` in 1: system clock.
- `Rst` in 1: reset. Synchronous, active-high; clock `clk`.
- `stall` in 1: pipeline hold (`mem_hold`). Blocks trap entry and return acceptance.
- `irq` in N_IRQ: asynchronous interrupt requests.
- `irq_en` in N_IRQ: per-line enable (mie).
- `global_en` in 1: global interrupt enable (mstatus.MIE). Does not gate `ecall`.
- `irq_clr` in N_IRQ: one-cycle software clear of edge-pending bits (mip write).
- `ecall` in 1: ecall decoded in ID.
- `trap_ret` in 1: mret decoded in ID.
- `pending` out N_IRQ: pending bits (mip), unmasked view.
- `trapping` out 1: high while a trap is being entered or serviced.
- `trigger_trap` out 1: one-cycle pulse on trap entry.
- `trigger_trap_ret` out 1: one-cycle pulse on trap return.
- `cause` out 32: mcause value of the most recent trap taken.

## Operation
- Sync: each `irq[i]` passes through `SYNC_STAGES` flops, giving `irq_s[i]`. One extra flop gives `irq_q[i]`.
- Level line pending: `pending[i] = irq_s[i]`. `irq_clr[i]` has no effect.
- Edge line pending:
  - Set on `irq_s & ~irq_q`.
  - Cleared when its trap is taken or when `irq_clr[i]` is high.
  - If a set and a clear occur in the same cycle, set wins.
- Eligible interrupt: `global_en & |(pending & irq_en)`.
- Selection priority: `ecall` > lowest-index eligible line.
- FSM states `IDLE`, `ENTER`, `ACTIVE`, `EXIT`:
  - IDLE → ENTER when `!stall` and (`ecall` or eligible interrupt). Latch `cause` on this transition.
  - If an interrupt is selected on IDLE → ENTER and the line is edge mode, clear its pending bit.
  - ENTER → ACTIVE unconditionally. `stall` is ignored, so the entry pulse is exactly one cycle.
  - ACTIVE → EXIT when `trap_ret & !stall`.
  - ACTIVE ignores `ecall` and interrupts; nesting is not supported.
  - EXIT → IDLE unconditionally. A pending trap can be accepted from IDLE on the following cycle.
  - `trap_ret` in IDLE is ignored.
- Cause encoding:
  - ecall: `32'd11`.
  - irq i: `{1'b1, 31'(16+i)}`.
  - `cause` holds its value until the next IDLE → ENTER transition.
- Outputs are registered or decoded from state only:
  - `trigger_trap = (state==ENTER)`.
  - `trigger_trap_ret = (state==EXIT)`.
  - `trapping = (state==ENTER || state==ACTIVE)`.
- Reset (at any point, including mid-trap):
  - State returns to IDLE.
  - Sync flops, `irq_q` and edge-pending bits clear.
  - `cause` = 0; all outputs are 0.

## Timing
- ecall latency: `ecall` sampled high at edge k with `!stall` gives `trigger_trap` and `trapping` high after edge k. This is one cycle, identical to the existing trap path.
- Level irq latency: `irq` high before edge 1 makes `irq_s` high after edge `SYNC_STAGES`. `trigger_trap` is high after edge `SYNC_STAGES+1`.
- Edge irq latency: one cycle more than level, i.e. `trigger_trap` high after edge `SYNC_STAGES+2`.
- Pulse widths: `trigger_trap` and `trigger_trap_ret` are exactly one cycle each.
- `trapping` falls in the same cycle that `trigger_trap_ret` rises.
- Minimum spacing between two trap entries is 4 cycles: ENTER, ACTIVE, EXIT, IDLE.
- Effect of `stall` in IDLE or ACTIVE: no transition occurs. Requests and edge-pending bits are retained; level requests are not latched.

## Structure
- Package `riscv_trap_pkg` holds:
  - `trap_state_t` enum (IDLE/ENTER/ACTIVE/EXIT).
  - `CAUSE_ECALL_M = 32'd11`.
  - `IRQ_CAUSE_BASE = 16`.
  - `IRQ_BIT = 31`.
- Sub-module `irq_sync_edge` (params `SYNC_STAGES`, `EDGE`) takes one line and outputs `irq_s` and a rise pulse. It is instantiated `N_IRQ` times in a generate loop.
- Priority encoder, pending register and FSM live in the top module.

## Test plan
- ecall in IDLE:
  - `ecall`=1 for one cycle → `trigger_trap` pulses for one cycle and `cause`=0x0000000B.
  - `trap_ret` 5 cycles later → `trigger_trap_ret` pulses and `trapping` falls.
- Priority with N_IRQ=4, all level, all enabled, `global_en`=1:
  - `irq`=4'b1010 → `cause`=0x80000011 after 3 edges.
  - `ecall` asserted in the same cycle as `irq_s` → `cause`=0x0000000B.
- Masking:
  - `irq_en`=0 with `irq[2]` high → `pending[2]`=1 and no trap.
  - Setting `irq_en[2]` → trap next cycle, `cause`=0x80000012.
  - Setting `global_en`=0 → interrupt blocked, but `ecall` still traps.
- Edge mode with EDGE_MASK=4'b0001:
  - 1-cycle pulse on `irq[0]` → `pending[0]` latched and trap taken, `cause`=0x80000010, `pending[0]` cleared on entry.
  - New edge coinciding with `irq_clr[0]` → `pending[0]` stays 1.
- Stall:
  - `stall`=1 while an eligible irq is present → no entry.
  - `stall` released → `trigger_trap` the next cycle.
  - `stall` raised during ENTER → pulse is still one cycle.
- Reset mid-trap: `Rst` asserted in ACTIVE with `pending[0]` set → next cycle state is IDLE, all outputs 0, `cause`=0, `pending`=0.

Source files
------------

// File: rtl/riscv_trap_pkg.sv
// Shared types and constants for the Mini-RISC-V trap/interrupt controller.
package riscv_trap_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTER  = 2'd1,
        ACTIVE = 2'd2,
        EXIT   = 2'd3
    } trap_state_t;

    localparam logic [31:0] CAUSE_ECALL_M  = 32'd11;
    localparam int          IRQ_CAUSE_BASE = 16;
    localparam int          IRQ_BIT        = 31;

    // mcause for external line idx: interrupt flag plus platform cause code.
    function automatic logic [31:0] irq_cause(input int idx);
        return (32'd1 << IRQ_BIT) | 32'(IRQ_CAUSE_BASE + idx);
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt line: multi-flop synchroniser plus a one-flop history for
// rising-edge detection (edge detection only active when EDGE is set).
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE        = 1'b0
) (
    input  logic clk,
    input  logic Rst,
    input  logic irq_i,
    output logic irq_s_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   irq_q;

    always_ff @(posedge clk) begin
        if (Rst) begin
            sync_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
            irq_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign irq_s_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = EDGE ? (irq_s_o & ~irq_q) : 1'b0;

endmodule

// File: rtl/riscv_trap_ctrl.sv
// Trap controller: merges ecall with N_IRQ external interrupts, tracks pending
// state, picks by fixed priority and sequences IDLE/ENTER/ACTIVE/EXIT.
module riscv_trap_ctrl
    import riscv_trap_pkg::*;
#(
    parameter int               N_IRQ       = 4,
    parameter int               SYNC_STAGES = 2,
    parameter logic [N_IRQ-1:0] EDGE_MASK   = '0
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic             stall,
    input  logic [N_IRQ-1:0] irq,
    input  logic [N_IRQ-1:0] irq_en,
    input  logic             global_en,
    input  logic [N_IRQ-1:0] irq_clr,
    input  logic             ecall,
    input  logic             trap_ret,
    output logic [N_IRQ-1:0] pending,
    output logic             trapping,
    output logic             trigger_trap,
    output logic             trigger_trap_ret,
    output logic [31:0]      cause,
    output logic [1:0]       dbg_state
);

    trap_state_t      state_q, state_d;
    logic [N_IRQ-1:0] irq_s, irq_rise;
    logic [N_IRQ-1:0] pend_q, pend_d;
    logic [31:0]      cause_q, cause_d;
    logic [N_IRQ-1:0] elig, sel_oh, take_clr;
    logic [31:0]      irq_cause_sel;
    logic             take;

    for (genvar i = 0; i < N_IRQ; i++) begin : g_line
        irq_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES),
            .EDGE       (EDGE_MASK[i])
        ) u_sync (
            .clk    (clk),
            .Rst    (Rst),
            .irq_i  (irq[i]),
            .irq_s_o(irq_s[i]),
            .rise_o (irq_rise[i])
        );
    end

    // Level lines mirror the synchronised input; edge lines are sticky.
    assign pending = (EDGE_MASK & pend_q) | (~EDGE_MASK & irq_s);
    assign elig    = global_en ? (pending & irq_en) : '0;

    always_comb begin
        sel_oh        = '0;
        irq_cause_sel = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (elig[i]) begin
                sel_oh        = '0;
                sel_oh[i]     = 1'b1;
                irq_cause_sel = irq_cause(i);
            end
        end
    end

    // Trap entry only from IDLE and never while the pipeline is held.
    assign take     = (state_q == IDLE) && !stall && (ecall || (|elig));
    assign take_clr = (take && !ecall) ? sel_oh : '0;

    // Set wins over both software clear and the clear-on-entry.
    assign pend_d  = (irq_rise | (pend_q & ~irq_clr & ~take_clr)) & EDGE_MASK;
    assign cause_d = take ? (ecall ? CAUSE_ECALL_M : irq_cause_sel) : cause_q;

    always_ff @(posedge clk) begin
        if (Rst) begin
            pend_q  <= '0;
            cause_q <= '0;
        end else begin
            pend_q  <= pend_d;
            cause_q <= cause_d;
        end
    end

    always_ff @(posedge clk) begin
        if (Rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take) state_d = ENTER;
            ENTER:   state_d = ACTIVE;
            ACTIVE:  if (trap_ret && !stall) state_d = EXIT;
            EXIT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        trigger_trap     = (state_q == ENTER);
        trigger_trap_ret = (state_q == EXIT);
        trapping         = (state_q == ENTER) || (state_q == ACTIVE);
    end

    assign cause     = cause_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_riscv_trap_ctrl.sv
// Bench for riscv_trap_ctrl: directed scenarios then random traffic, all
// checked cycle by cycle against a behavioural model and a cause scoreboard.
module tb_riscv_trap_ctrl;

    localparam int         N  = 4;
    localparam int         SS = 2;
    localparam logic [3:0] EM = 4'b0001;

    logic        clk = 1'b0;
    logic        Rst = 1'b1;
    logic        stall = 1'b0;
    logic [3:0]  irq = '0, irq_en = 4'hF, irq_clr = '0;
    logic        global_en = 1'b1, ecall = 1'b0, trap_ret = 1'b0;
    logic [3:0]  pending;
    logic        trapping, trigger_trap, trigger_trap_ret;
    logic [31:0] cause;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state
    logic [3:0]  hist [0:3];
    logic [3:0]  m_pend;
    logic        m_in_trap, m_entered, m_returned;
    logic [31:0] m_cause;
    logic [31:0] exp_q [$];

    riscv_trap_ctrl #(.N_IRQ(N), .SYNC_STAGES(SS), .EDGE_MASK(EM)) dut (
        .clk             (clk),
        .Rst             (Rst),
        .stall           (stall),
        .irq             (irq),
        .irq_en          (irq_en),
        .global_en       (global_en),
        .irq_clr         (irq_clr),
        .ecall           (ecall),
        .trap_ret        (trap_ret),
        .pending         (pending),
        .trapping        (trapping),
        .trigger_trap    (trigger_trap),
        .trigger_trap_ret(trigger_trap_ret),
        .cause           (cause),
        .dbg_state       (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) hist[k] = '0;
        m_pend     = '0;
        m_in_trap  = 1'b0;
        m_entered  = 1'b0;
        m_returned = 1'b0;
        m_cause    = '0;
        exp_q.delete();
    endtask

    // One clock of the model, using the inputs the DUT samples at this edge.
    task automatic model_step();
        logic [3:0] s, q, pv, elig, rise;
        int         pick;
        logic       accept;
        if (Rst) begin
            model_reset();
            return;
        end
        s    = hist[SS-1];
        q    = hist[SS];
        pv   = (EM & m_pend) | (~EM & s);
        elig = global_en ? (pv & irq_en) : 4'b0;
        pick = -1;
        for (int i = 0; i < N; i++) if (elig[i] && pick < 0) pick = i;
        accept = !m_in_trap && !m_returned && !stall && (ecall || pick >= 0);
        rise   = EM & s & ~q;
        for (int i = 0; i < N; i++)
            m_pend[i] = rise[i] | (m_pend[i] & ~irq_clr[i] & !(accept && !ecall && pick == i));
        if (m_returned) m_returned = 1'b0;
        else if (m_entered) m_entered = 1'b0;
        else if (m_in_trap) begin
            if (trap_ret && !stall) begin
                m_in_trap  = 1'b0;
                m_returned = 1'b1;
            end
        end else if (accept) begin
            m_in_trap = 1'b1;
            m_entered = 1'b1;
            m_cause   = ecall ? 32'd11 : 32'h8000_0000 + 32'(16 + pick);
            exp_q.push_back(m_cause);
        end
        for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = irq;
    endtask

    task automatic compare_all();
        logic [3:0] exp_pend;
        exp_pend = (EM & m_pend) | (~EM & hist[SS-1]);
        check("trigger_trap", 32'(trigger_trap), 32'(m_entered));
        check("trigger_trap_ret", 32'(trigger_trap_ret), 32'(m_returned));
        check("trapping", 32'(trapping), 32'(m_in_trap));
        check("cause", cause, m_cause);
        check("pending", 32'(pending), 32'(exp_pend));
        if (trigger_trap) begin
            if (exp_q.size() == 0) check("sb_unexpected_trap", 32'(exp_q.size()), 32'd1);
            else check("sb_cause", cause, exp_q.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    // From ENTER: through ACTIVE and EXIT back to IDLE.
    task automatic leave_trap();
        trap_ret = 1'b1;
        tick();
        tick();
        trap_ret = 1'b0;
        tick();
    endtask

    initial begin
        logic [3:0] flip;
        model_reset();

        // Reset
        repeat (3) tick();
        check("rst_cause", cause, 32'd0);
        check("rst_trapping", 32'(trapping), 32'd0);
        Rst = 1'b0;

        // ecall in IDLE
        ecall = 1'b1; tick();
        check("ecall_trigger", 32'(trigger_trap), 32'd1);
        check("ecall_cause", cause, 32'h0000_000B);
        ecall = 1'b0; tick();
        check("ecall_pulse_width", 32'(trigger_trap), 32'd0);
        repeat (4) tick();
        trap_ret = 1'b1; tick();
        check("ret_pulse", 32'(trigger_trap_ret), 32'd1);
        check("ret_trapping_low", 32'(trapping), 32'd0);
        trap_ret = 1'b0; tick();

        // Priority among level lines, then ecall beating a present irq
        irq = 4'b1010;
        repeat (3) tick();
        check("prio_cause", cause, 32'h8000_0011);
        trap_ret = 1'b1; tick(); tick();
        trap_ret = 1'b0; ecall = 1'b1; tick();
        check("exit_blocks_entry", 32'(trapping), 32'd0);
        tick();
        check("ecall_over_irq", cause, 32'h0000_000B);
        ecall = 1'b0; irq = 4'b0000;
        leave_trap();

        // Masking
        irq_en = 4'b1011; irq = 4'b0100;
        repeat (3) tick();
        check("masked_pending", 32'(pending), 32'h4);
        check("masked_no_trap", 32'(trapping), 32'd0);
        irq_en = 4'hF; tick();
        check("unmask_cause", cause, 32'h8000_0012);
        irq = 4'b0000; leave_trap();
        global_en = 1'b0; irq = 4'b0100;
        repeat (3) tick();
        check("global_off_no_trap", 32'(trapping), 32'd0);
        ecall = 1'b1; tick();
        check("global_off_ecall", cause, 32'h0000_000B);
        ecall = 1'b0; irq = 4'b0000; leave_trap();
        global_en = 1'b1;

        // Edge line 0
        irq = 4'b0001; tick();
        irq = 4'b0000; tick(); tick();
        check("edge_pending_set", 32'(pending[0]), 32'd1);
        tick();
        check("edge_trigger", 32'(trigger_trap), 32'd1);
        check("edge_cause", cause, 32'h8000_0010);
        check("edge_clear_on_entry", 32'(pending[0]), 32'd0);
        leave_trap();

        // Set and clear together, held off by stall
        irq = 4'b0001; tick();
        irq = 4'b0000; tick();
        stall = 1'b1; irq_clr = 4'b0001; tick();
        check("set_beats_clr", 32'(pending[0]), 32'd1);
        irq_clr = 4'b0000; tick();
        check("stall_blocks_entry", 32'(trapping), 32'd0);
        stall = 1'b0; tick();
        check("stall_release_trigger", 32'(trigger_trap), 32'd1);
        stall = 1'b1; tick();
        check("stall_in_enter_pulse", 32'(trigger_trap), 32'd0);
        check("stall_in_enter_active", 32'(trapping), 32'd1);
        stall = 1'b0;

        // Reset while ACTIVE with an edge pending
        irq = 4'b0001; tick();
        irq = 4'b0000; tick(); tick();
        check("midtrap_pending", 32'(pending[0]), 32'd1);
        Rst = 1'b1; tick();
        check("midtrap_rst_cause", cause, 32'd0);
        check("midtrap_rst_pending", 32'(pending), 32'd0);
        check("midtrap_rst_trapping", 32'(trapping), 32'd0);
        Rst = 1'b0;

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            Rst      = ($urandom_range(0, 299) == 0);
            stall    = ($urandom_range(0, 4) == 0);
            flip     = 4'($urandom) & 4'($urandom) & 4'($urandom);
            irq      = irq ^ flip;
            irq_clr  = 4'($urandom) & 4'($urandom);
            ecall    = ($urandom_range(0, 19) == 0);
            trap_ret = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 49) == 0) irq_en = 4'($urandom);
            if ($urandom_range(0, 39) == 0) global_en = ~global_en;
            tick();
        end

        Rst = 1'b0; stall = 1'b0; ecall = 1'b0; trap_ret = 1'b1; irq = '0; irq_clr = '0;
        repeat (4) tick();
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
